pipeline_hazard_ctrl: RTL and testbench

//  Hazard and sequencing controller for the 5-stage MIPS pipeline. It generates the registered

---
 rtl/pipeline_pkg.sv | 20 ++
 rtl/fwd_select.sv | 24 ++
 rtl/pipeline_hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipeline_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned FWD_W      = 2;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_STEP = 2'd2
    } pipe_state_e;

    typedef logic [FWD_W-1:0] fwd_sel_t;

    // Encodings of the EX-stage operand mux select.
    localparam fwd_sel_t FWD_REGFILE = 2'b00;
    localparam fwd_sel_t FWD_MEM     = 2'b01;
    localparam fwd_sel_t FWD_WB      = 2'b10;

endpackage

// File: rtl/fwd_select.sv
// Operand forwarding select for one ID source register; the EX producer beats the MEM producer.
module fwd_select
    import pipeline_pkg::*;
#(
    parameter int unsigned ADDR_W = REG_ADDR_W
) (
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] ex_rd,
    input  logic              ex_regwrite,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic              mem_regwrite,
    output fwd_sel_t          sel_c
);

    always_comb begin
        sel_c = FWD_REGFILE;
        if (ex_regwrite && (ex_rd != '0) && (ex_rd == src)) begin
            sel_c = FWD_MEM;
        end else if (mem_regwrite && (mem_rd != '0) && (mem_rd == src)) begin
            sel_c = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller: forwarding selects, stall/flush strobes, debug halt/step
// sequencing of the global pipeline enable, and a saturating hazard-cycle counter.
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_ADDR_W   = pipeline_pkg::REG_ADDR_W,
    parameter int unsigned CNT_W        = 16,
    parameter bit          START_HALTED = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [REG_ADDR_W-1:0] i_id_rs,
    input  logic [REG_ADDR_W-1:0] i_id_rt,
    input  logic [REG_ADDR_W-1:0] i_ex_rd,
    input  logic                  i_ex_regwrite,
    input  logic                  i_ex_memread,
    input  logic [REG_ADDR_W-1:0] i_mem_rd,
    input  logic                  i_mem_regwrite,
    input  logic                  i_branch_taken,
    input  logic                  i_dbg_halt_req,
    input  logic                  i_dbg_step,
    input  logic                  i_dbg_cnt_clr,
    output logic [1:0]            o_fwd_a_sel,
    output logic [1:0]            o_fwd_b_sel,
    output logic                  o_pipe_en,
    output logic                  o_pc_write,
    output logic                  o_ifid_write,
    output logic                  o_idex_bubble,
    output logic                  o_ifid_flush,
    output logic                  o_halted,
    output logic [CNT_W-1:0]      o_hazard_cnt
);

    import pipeline_pkg::*;

    localparam pipe_state_e       RESET_STATE = START_HALTED ? ST_HALT : ST_RUN;
    localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

    pipe_state_e      state_q, state_d;
    fwd_sel_t         fwd_a_q, fwd_b_q;
    fwd_sel_t         fwd_a_c, fwd_b_c;
    logic [CNT_W-1:0] cnt_q;
    logic             pipe_en_c;
    logic             load_use_c;
    logic             pc_write_c, ifid_write_c, bubble_c, flush_c;

    assign pipe_en_c  = (state_q != ST_HALT);
    assign load_use_c = i_ex_memread && (i_ex_rd != '0) &&
                        ((i_ex_rd == i_id_rs) || (i_ex_rd == i_id_rt));

    // Debug sequencing: STEP is a single enabled cycle taken only from HALT.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:  if (i_dbg_halt_req) state_d = ST_HALT;
            ST_HALT: begin
                if (i_dbg_step)          state_d = ST_STEP;
                else if (!i_dbg_halt_req) state_d = ST_RUN;
            end
            ST_STEP: state_d = i_dbg_halt_req ? ST_HALT : ST_RUN;
            default: state_d = RESET_STATE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state_q <= RESET_STATE;
        else            state_q <= state_d;
    end

    // A taken branch flushes younger work, so it overrides a load-use stall.
    always_comb begin
        pc_write_c   = 1'b0;
        ifid_write_c = 1'b0;
        bubble_c     = 1'b0;
        flush_c      = 1'b0;
        if (pipe_en_c) begin
            if (i_branch_taken) begin
                pc_write_c   = 1'b1;
                ifid_write_c = 1'b1;
                bubble_c     = 1'b1;
                flush_c      = 1'b1;
            end else if (load_use_c) begin
                bubble_c     = 1'b1;
            end else begin
                pc_write_c   = 1'b1;
                ifid_write_c = 1'b1;
            end
        end
    end

    fwd_select #(.ADDR_W(REG_ADDR_W)) u_fwd_a (
        .src          (i_id_rs),
        .ex_rd        (i_ex_rd),
        .ex_regwrite  (i_ex_regwrite),
        .mem_rd       (i_mem_rd),
        .mem_regwrite (i_mem_regwrite),
        .sel_c        (fwd_a_c)
    );

    fwd_select #(.ADDR_W(REG_ADDR_W)) u_fwd_b (
        .src          (i_id_rt),
        .ex_rd        (i_ex_rd),
        .ex_regwrite  (i_ex_regwrite),
        .mem_rd       (i_mem_rd),
        .mem_regwrite (i_mem_regwrite),
        .sel_c        (fwd_b_c)
    );

    // Selects advance with the ID/EX register; a bubbled or flushed slot reads the regfile.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            fwd_a_q <= FWD_REGFILE;
            fwd_b_q <= FWD_REGFILE;
        end else if (pipe_en_c) begin
            fwd_a_q <= (bubble_c || flush_c) ? FWD_REGFILE : fwd_a_c;
            fwd_b_q <= (bubble_c || flush_c) ? FWD_REGFILE : fwd_b_c;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q <= '0;
        end else if (i_dbg_cnt_clr) begin
            cnt_q <= '0;
        end else if (pipe_en_c && bubble_c && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign o_fwd_a_sel   = fwd_a_q;
    assign o_fwd_b_sel   = fwd_b_q;
    assign o_pipe_en     = pipe_en_c;
    assign o_halted      = (state_q == ST_HALT);
    assign o_pc_write    = pc_write_c;
    assign o_ifid_write  = ifid_write_c;
    assign o_idex_bubble = bubble_c;
    assign o_ifid_flush  = flush_c;
    assign o_hazard_cnt  = cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed literal checks plus random stimulus against a cycle model.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs, id_rt, ex_rd, mem_rd;
    logic        ex_regwrite, ex_memread, mem_regwrite, branch_taken;
    logic        halt_req, step, cnt_clr;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic        pipe_en, pc_write, ifid_write, idex_bubble, ifid_flush, halted;
    logic [15:0] hazard_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: which debug mode the controller is in, plus registered outputs.
    bit m_halt;
    bit m_step;
    int m_fa, m_fb, m_cnt;

    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(16), .START_HALTED(1'b1)) dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_id_rs        (id_rs),
        .i_id_rt        (id_rt),
        .i_ex_rd        (ex_rd),
        .i_ex_regwrite  (ex_regwrite),
        .i_ex_memread   (ex_memread),
        .i_mem_rd       (mem_rd),
        .i_mem_regwrite (mem_regwrite),
        .i_branch_taken (branch_taken),
        .i_dbg_halt_req (halt_req),
        .i_dbg_step     (step),
        .i_dbg_cnt_clr  (cnt_clr),
        .o_fwd_a_sel    (fwd_a_sel),
        .o_fwd_b_sel    (fwd_b_sel),
        .o_pipe_en      (pipe_en),
        .o_pc_write     (pc_write),
        .o_ifid_write   (ifid_write),
        .o_idex_bubble  (idex_bubble),
        .o_ifid_flush   (ifid_flush),
        .o_halted       (halted),
        .o_hazard_cnt   (hazard_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int fwd_model(int src, int erd, bit ew, int mrd, bit mw);
        if (ew && erd != 0 && erd == src) return 1;
        if (mw && mrd != 0 && mrd == src) return 2;
        return 0;
    endfunction

    // Compare every cycle, then advance the model to the state after the coming rising edge.
    always @(negedge clk) begin
        bit pe, lu, e_pcw, e_ifw, e_bub, e_fl;
        if (!rst_n) begin
            m_halt = 1'b1; m_step = 1'b0; m_fa = 0; m_fb = 0; m_cnt = 0;
        end
        pe = !m_halt;
        lu = ex_memread && ex_rd != 0 && (ex_rd == id_rs || ex_rd == id_rt);
        e_pcw = 0; e_ifw = 0; e_bub = 0; e_fl = 0;
        if (pe) begin
            if (branch_taken) begin e_pcw = 1; e_ifw = 1; e_bub = 1; e_fl = 1; end
            else if (lu) e_bub = 1;
            else begin e_pcw = 1; e_ifw = 1; end
        end
        check("m_halted", halted, m_halt);
        check("m_pipe_en", pipe_en, pe);
        check("m_pc_write", pc_write, e_pcw);
        check("m_ifid_write", ifid_write, e_ifw);
        check("m_bubble", idex_bubble, e_bub);
        check("m_flush", ifid_flush, e_fl);
        check("m_fwd_a", fwd_a_sel, m_fa);
        check("m_fwd_b", fwd_b_sel, m_fb);
        check("m_cnt", hazard_cnt, m_cnt);
        if (rst_n) begin
            if (pe) begin
                m_fa = (e_bub || e_fl) ? 0 : fwd_model(id_rs, ex_rd, ex_regwrite, mem_rd, mem_regwrite);
                m_fb = (e_bub || e_fl) ? 0 : fwd_model(id_rt, ex_rd, ex_regwrite, mem_rd, mem_regwrite);
            end
            if (cnt_clr) m_cnt = 0;
            else if (pe && e_bub && m_cnt < 65535) m_cnt = m_cnt + 1;
            if (m_halt) begin
                if (step) begin m_halt = 0; m_step = 1; end
                else if (!halt_req) m_halt = 0;
            end else if (m_step) begin
                m_step = 0; m_halt = halt_req;
            end else begin
                m_halt = halt_req;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pipe(int rs, int rt, int erd, bit ew, bit emr, int mrd, bit mw, bit br);
        id_rs = 5'(rs); id_rt = 5'(rt); ex_rd = 5'(erd); ex_regwrite = ew;
        ex_memread = emr; mem_rd = 5'(mrd); mem_regwrite = mw; branch_taken = br;
    endtask

    initial begin
        rst_n = 1'b0; halt_req = 1'b1; step = 1'b0; cnt_clr = 1'b0;
        set_pipe(0, 0, 0, 0, 0, 0, 0, 0);
        tick(); #2;
        check("rst_halted", halted, 1);
        check("rst_pipe_en", pipe_en, 0);
        check("rst_fwd_a", fwd_a_sel, 0);
        check("rst_fwd_b", fwd_b_sel, 0);
        check("rst_cnt", hazard_cnt, 0);
        tick(); rst_n = 1'b1; #2;
        check("hold_halted", halted, 1);
        tick(); halt_req = 1'b0; #2;
        check("still_halted", halted, 1);
        // load-use on rs
        tick(); set_pipe(8, 0, 8, 1, 1, 0, 0, 0); #2;
        check("run_after_release", halted, 0);
        check("lu_pc_write", pc_write, 0);
        check("lu_ifid_write", ifid_write, 0);
        check("lu_bubble", idex_bubble, 1);
        tick(); set_pipe(0, 3, 3, 1, 0, 3, 1, 0); #2;
        check("lu_fwd_a_zero", fwd_a_sel, 0);
        check("lu_cnt", hazard_cnt, 1);
        check("nohaz_pc_write", pc_write, 1);
        tick(); set_pipe(0, 0, 0, 1, 0, 0, 1, 0); #2;
        check("ex_prio_fwd_b", fwd_b_sel, 1);
        tick(); set_pipe(3, 3, 0, 1, 0, 3, 1, 0); #2;
        check("zero_reg_fwd_b", fwd_b_sel, 0);
        tick(); set_pipe(8, 0, 8, 1, 1, 0, 0, 1); #2;
        check("mem_fwd_a", fwd_a_sel, 2);
        check("mem_fwd_b", fwd_b_sel, 2);
        check("br_flush", ifid_flush, 1);
        check("br_bubble", idex_bubble, 1);
        check("br_pc_write", pc_write, 1);
        tick(); set_pipe(0, 0, 0, 0, 0, 0, 0, 0); step = 1'b1; #2;
        check("br_fwd_a_zero", fwd_a_sel, 0);
        check("br_cnt", hazard_cnt, 2);
        tick(); step = 1'b0; #2;
        check("step_in_run", halted, 0);
        tick(); halt_req = 1'b1; #2;
        check("run_before_halt", halted, 0);
        tick(); branch_taken = 1'b1; #2;
        check("halt_entered", halted, 1);
        check("halt_pc_write", pc_write, 0);
        check("halt_flush", ifid_flush, 0);
        check("halt_ifid_write", ifid_write, 0);
        // two single-step pulses
        for (int k = 0; k < 2; k++) begin
            tick(); branch_taken = 1'b0; step = 1'b1; #2;
            check("step_pre", pipe_en, 0);
            tick(); step = 1'b0; #2;
            check("step_en", pipe_en, 1);
            tick(); #2;
            check("step_done", pipe_en, 0);
        end
        // halt request during a load-use stall
        tick(); halt_req = 1'b0; #2;
        tick(); set_pipe(5, 0, 5, 1, 1, 0, 0, 0); halt_req = 1'b1; #2;
        check("hlu_bubble", idex_bubble, 1);
        check("hlu_pc_write", pc_write, 0);
        tick(); #2;
        check("hlu_halted", halted, 1);
        check("hlu_bubble_off", idex_bubble, 0);
        check("hlu_cnt", hazard_cnt, 3);
        tick(); halt_req = 1'b0; #2;
        tick(); #2;
        check("hlu_resume_bubble", idex_bubble, 1);
        // async reset while in STEP
        tick(); set_pipe(0, 0, 0, 0, 0, 0, 0, 0); halt_req = 1'b1; #2;
        tick(); step = 1'b1; #2;
        tick(); step = 1'b0; #2;
        check("in_step", pipe_en, 1);
        rst_n = 1'b0; #1;
        check("arst_halted", halted, 1);
        check("arst_cnt", hazard_cnt, 0);
        check("arst_pipe_en", pipe_en, 0);
        tick(); rst_n = 1'b1;
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            tick();
            set_pipe($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                     1'($urandom), 1'($urandom), $urandom_range(0, 3), 1'($urandom),
                     ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 9) == 0) halt_req = ~halt_req;
            step    = ($urandom_range(0, 3) == 0);
            cnt_clr = ($urandom_range(0, 63) == 0);
        end
        // saturate the counter with a continuous stall
        tick(); halt_req = 1'b0; step = 1'b0; cnt_clr = 1'b0;
        set_pipe(6, 0, 6, 1, 1, 0, 0, 0);
        repeat (65600) tick();
        #2;
        check("sat_cnt", hazard_cnt, 65535);
        tick(); cnt_clr = 1'b1;
        tick(); cnt_clr = 1'b0; #2;
        check("clr_wins", hazard_cnt, 0);
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
